// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RISC-V load/store unit in front of a word-wide data memory
// Optional feature: define MEM_ACCESS_MISALIGN_EN to reject misaligned halfword/word accesses.
module mem_access_unit #(
  parameter int DATA_WIDTH           = 32,
  parameter int MEMORY_ADDRESS_WIDTH = 10,
  parameter int ADDR_WIDTH           = MEMORY_ADDRESS_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_next;

  logic        wr_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        misaligned;
  logic        req_err;

`ifdef MEM_ACCESS_MISALIGN_EN
  assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Unsupported width codes and unsigned stores never touch memory.
  assign req_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_write && req_funct3[2]) || misaligned;

  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [2:0]            f3,
    input logic [1:0]            lane
  );
    logic [4:0]            amt;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] res;
    amt = f3[0] ? {lane[1], 4'b0000} : {lane, 3'b000};
    sh  = word >> amt;
    case (f3[1:0])
      2'b00:   res = {{(DATA_WIDTH-8){~f3[2] & sh[7]}}, sh[7:0]};
      2'b01:   res = {{(DATA_WIDTH-16){~f3[2] & sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] word,
    input logic [15:0]           wd,
    input logic                  half,
    input logic [1:0]            lane
  );
    logic [4:0]            amt;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] ins;
    if (half) begin
      amt  = {lane[1], 4'b0000};
      mask = DATA_WIDTH'(16'hFFFF) << amt;
      ins  = DATA_WIDTH'(wd) << amt;
    end else begin
      amt  = {lane, 3'b000};
      mask = DATA_WIDTH'(8'hFF) << amt;
      ins  = DATA_WIDTH'(wd[7:0]) << amt;
    end
    return (word & ~mask) | ins;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                                state_next = DONE;
          else if (req_write && req_funct3 == 3'b010) state_next = WR;
          else                                        state_next = RD;
        end
      end
      RD: state_next = wr_q ? WR : DONE;
      WR: begin
        mem_write_en = 1'b1;
        state_next   = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response registers change only on the edge entering DONE so they hold between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q           <= 1'b0;
      f3_q           <= 3'b000;
      lane_q         <= 2'b00;
      wdata_q        <= '0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            if (req_err) begin
              resp_rdata <= '0;
              resp_error <= 1'b1;
            end else begin
              mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (req_write) mem_write_data <= req_wdata;
            end
          end
        end
        RD: begin
          if (wr_q) begin
            mem_write_data <= store_merge(mem_read_data, wdata_q, f3_q[0], lane_q);
          end else begin
            resp_rdata <= load_extract(mem_read_data, f3_q, lane_q);
            resp_error <= 1'b0;
          end
        end
        WR: begin
          resp_rdata <= '0;
          resp_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int DW  = 32;
  localparam int MAW = 10;
  localparam int AW  = MAW + 2;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_error;
  logic [AW-1:0] mem_address;
  logic          mem_write_en;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  mem_access_unit #(.DATA_WIDTH(DW), .MEMORY_ADDRESS_WIDTH(MAW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]    mem [0:(1<<MAW)-1];
  logic           pre_en;
  logic [MAW-1:0] pre_idx;
  logic [31:0]    pre_data;

  assign mem_read_data = mem[mem_address[AW-1:2]];

  always @(posedge clk) begin
    if (mem_write_en)  mem[mem_address[AW-1:2]] <= mem_write_data;
    else if (pre_en)   mem[pre_idx] <= pre_data;
  end

  int compared;
  int mismatched;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: memory seen as four bytes; accesses pick size bytes at the size-aligned offset.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [AW-1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] old,
                       output logic err, output logic [31:0] rdata, output int lat,
                       output int nwr, output int wcyc, output logic [31:0] wword);
    int          size;
    int          ofs;
    logic [7:0]  b [4];
    logic [31:0] val;
    size = 1 << f3[1:0];
    err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3 >= 3'd4);
`ifdef MEM_ACCESS_MISALIGN_EN
    if ((int'(addr) % size) != 0) err = 1'b1;
`endif
    rdata = 32'h0; nwr = 0; wcyc = 0; wword = old; lat = 1;
    if (!err) begin
      ofs = (int'(addr[1:0]) / size) * size;
      for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
      if (!wr) begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val = val | (32'(b[ofs+i]) << (8*i));
        if (f3 < 3'd4 && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        rdata = val;
        lat   = 2;
      end else begin
        for (int i = 0; i < size; i++) b[ofs+i] = wdata[8*i +: 8];
        wword = {b[3], b[2], b[1], b[0]};
        nwr   = 1;
        lat   = (size == 4) ? 2 : 3;
        wcyc  = lat - 1;
      end
    end
  endtask

  logic [31:0] r_rdata, r_wword, r_final, r_hold;
  logic        r_err, r_align_bad, r_ready1, r_valid_after, r_ready_after;
  int          r_lat, r_nwr, r_wcyc;

  task automatic do_access(input logic wr, input logic [2:0] f3, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input logic [31:0] old);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = addr[AW-1:2]; pre_data = old;
    @(negedge clk);
    pre_en = 1'b0;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    r_lat = 0; r_nwr = 0; r_wcyc = 0; r_wword = 32'h0; r_align_bad = 1'b0; r_ready1 = 1'b1;
    r_rdata = 32'hDEAD_DEAD; r_err = 1'bx;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 8 && r_lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) r_ready1 = req_ready;
      if (mem_address[1:0] != 2'b00) r_align_bad = 1'b1;
      if (mem_write_en) begin
        r_nwr++;
        r_wcyc  = c;
        r_wword = mem_write_data;
      end
      if (resp_valid) begin
        r_lat   = c;
        r_rdata = resp_rdata;
        r_err   = resp_error;
      end
    end
    @(negedge clk);
    r_valid_after = resp_valid;
    r_ready_after = req_ready;
    r_hold        = resp_rdata;
    r_final       = mem[addr[AW-1:2]];
  endtask

  task automatic run_check(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [AW-1:0] addr, input logic [31:0] wdata, input logic [31:0] old,
                           input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                           input int e_nwr, input int e_wcyc, input logic [31:0] e_wword);
    do_access(wr, f3, addr, wdata, old);
    check({tag, ".latency"}, 32'(r_lat), 32'(e_lat));
    check({tag, ".rdata"}, r_rdata, e_rdata);
    check({tag, ".error"}, 32'(r_err), 32'(e_err));
    check({tag, ".writes"}, 32'(r_nwr), 32'(e_nwr));
    if (e_nwr != 0) begin
      check({tag, ".write_cycle"}, 32'(r_wcyc), 32'(e_wcyc));
      check({tag, ".write_word"}, r_wword, e_wword);
    end
    check({tag, ".mem_after"}, r_final, (e_nwr != 0) ? e_wword : old);
    check({tag, ".ready_busy"}, 32'(r_ready1), 32'h0);
    check({tag, ".addr_aligned"}, 32'(r_align_bad), 32'h0);
    check({tag, ".valid_pulse"}, 32'(r_valid_after), 32'h0);
    check({tag, ".ready_after"}, 32'(r_ready_after), 32'h1);
    check({tag, ".rdata_hold"}, r_hold, e_rdata);
  endtask

  typedef struct {
    logic          wr;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   old;
    logic [31:0]   e_rdata;
    logic          e_err;
    int            e_lat;
    int            e_nwr;
    int            e_wcyc;
    logic [31:0]   e_wword;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          m_err;
    logic [31:0]   m_rdata, m_wword;
    int            m_lat, m_nwr, m_wcyc;
    logic          t_wr;
    logic [2:0]    t_f3;
    logic [AW-1:0] t_addr;
    logic [31:0]   t_wdata, t_old;
    logic          saw_valid;

    compared = 0; mismatched = 0;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; pre_en = 1'b0; pre_idx = '0; pre_data = '0;

    vecs.push_back('{1'b0, 3'b010, 12'h010, 32'h0, 32'h8000_00F0, 32'h8000_00F0, 1'b0, 2, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 3'b000, 12'h013, 32'h0, 32'h8012_3456, 32'hFFFF_FF80, 1'b0, 2, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 3'b100, 12'h013, 32'h0, 32'h8012_3456, 32'h0000_0080, 1'b0, 2, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 3'b000, 12'h021, 32'h0000_00AB, 32'h1122_3344, 32'h0, 1'b0, 3, 1, 2, 32'h1122_AB44});
    vecs.push_back('{1'b1, 3'b000, 12'h022, 32'hFFFF_FF5A, 32'h1122_3344, 32'h0, 1'b0, 3, 1, 2, 32'h115A_3344});
    vecs.push_back('{1'b1, 3'b001, 12'h042, 32'h1234_5678, 32'hAAAA_BBBB, 32'h0, 1'b0, 3, 1, 2, 32'h5678_BBBB});
    vecs.push_back('{1'b1, 3'b010, 12'h040, 32'hCAFE_BABE, 32'h0, 32'h0, 1'b0, 2, 1, 1, 32'hCAFE_BABE});
    vecs.push_back('{1'b0, 3'b101, 12'h00A, 32'h0, 32'h8001_7FFF, 32'h0000_8001, 1'b0, 2, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 3'b001, 12'h00A, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 2, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 3'b000, 12'h00A, 32'h0, 32'h8001_7FFF, 32'h0000_0001, 1'b0, 2, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 3'b011, 12'h030, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 3'b110, 12'h034, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 3'b100, 12'h050, 32'h0000_00FF, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 3'b111, 12'h054, 32'h0000_00FF, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 0, 32'h0});
`ifdef MEM_ACCESS_MISALIGN_EN
    vecs.push_back('{1'b0, 3'b001, 12'h005, 32'h0, 32'h9ABC_8765, 32'h0, 1'b1, 1, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 3'b010, 12'h00E, 32'h0, 32'h0102_0304, 32'h0, 1'b1, 1, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 12'h043, 32'h0000_BEEF, 32'h1122_3344, 32'h0, 1'b1, 1, 0, 0, 32'h0});
`else
    vecs.push_back('{1'b0, 3'b001, 12'h005, 32'h0, 32'h9ABC_8765, 32'hFFFF_8765, 1'b0, 2, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 3'b010, 12'h00E, 32'h0, 32'h0102_0304, 32'h0102_0304, 1'b0, 2, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 12'h043, 32'h0000_BEEF, 32'h1122_3344, 32'h0, 1'b0, 3, 1, 2, 32'hBEEF_3344});
`endif

    repeat (2) @(negedge clk);
    check("reset.req_ready", 32'(req_ready), 32'h1);
    check("reset.resp_valid", 32'(resp_valid), 32'h0);
    check("reset.resp_error", 32'(resp_error), 32'h0);
    check("reset.resp_rdata", resp_rdata, 32'h0);
    check("reset.mem_write_en", 32'(mem_write_en), 32'h0);
    check("reset.mem_address", 32'(mem_address), 32'h0);
    check("reset.mem_write_data", mem_write_data, 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].old, vecs[i].e_rdata, vecs[i].e_err, vecs[i].e_lat, vecs[i].e_nwr,
                vecs[i].e_wcyc, vecs[i].e_wword);
    end

    // SW interrupted by reset while the write strobe is up.
    @(negedge clk);
    pre_en = 1'b1; pre_idx = 10'h018; pre_data = 32'h5555_5555;
    @(negedge clk);
    pre_en = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 12'h060; req_wdata = 32'h0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstwr.wen_before", 32'(mem_write_en), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rstwr.wen_dropped", 32'(mem_write_en), 32'h0);
    check("rstwr.req_ready", 32'(req_ready), 32'h1);
    check("rstwr.resp_valid", 32'(resp_valid), 32'h0);
    check("rstwr.mem_address", 32'(mem_address), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_write_en) saw_valid = 1'b1;
    end
    check("rstwr.no_response", 32'(saw_valid), 32'h0);
    check("rstwr.mem_untouched", mem[10'h018], 32'h5555_5555);

    for (int n = 0; n < 150; n++) begin
      t_wr    = 1'($urandom_range(0, 1));
      t_f3    = 3'($urandom_range(0, 7));
      t_addr  = AW'($urandom_range(0, (1 << AW) - 1));
      t_wdata = $urandom;
      t_old   = $urandom;
      model(t_wr, t_f3, t_addr, t_wdata, t_old, m_err, m_rdata, m_lat, m_nwr, m_wcyc, m_wword);
      run_check($sformatf("rnd%0d", n), t_wr, t_f3, t_addr, t_wdata, t_old,
                m_rdata, m_err, m_lat, m_nwr, m_wcyc, m_wword);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the data path.
REQ-002 Parameter: ADDR_WIDTH, default MEMORY_ADDRESS_WIDTH+2, byte-address width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  core requests an access.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  ADDR_WIDTH  byte address.
REQ-010 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 resp_valid  output  1  access complete, one-cycle pulse.
REQ-012 resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores and errors.
REQ-013 resp_error  output  1  access rejected; valid with resp_valid.
REQ-014 mem_address  output  ADDR_WIDTH  byte address to data memory, always word-aligned (bits [1:0] = 0).
REQ-015 mem_write_en  output  1  word write strobe to data memory.
REQ-016 mem_write_data  output  DATA_WIDTH  full word to write.
REQ-017 mem_read_data  input  DATA_WIDTH  combinational word read of mem_address.

Function
REQ-018 The FSM SHALL have states IDLE, RD, WR, DONE, and req_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, on req_valid=1, the unit SHALL register write, funct3, addr and wdata, then branch as follows:
- error: DONE
- load or sub-word store: RD
- SW: WR
REQ-020 In RD, the unit SHALL drive mem_address={addr[ADDR_WIDTH-1:2],2'b00} and capture mem_read_data, then branch as follows:
- load: DONE
- store: WR
REQ-021 Load extraction:
- byte: lane addr[1:0]
- halfword: lane addr[1]
- B/H: sign-extended; BU/HU: zero-extended
- W: unchanged
REQ-022 In WR, the unit SHALL assert mem_write_en for exactly one cycle with mem_write_data as follows, then go to DONE:
- SW: the req_wdata word
- SB/SH: the captured word with only the addressed byte/halfword lane replaced from wdata[7:0]/[15:0]
REQ-023 In DONE, the unit SHALL assert resp_valid for one cycle, then return to IDLE; resp_rdata/resp_error SHALL hold until the next DONE.
REQ-024 Latency from accept edge to resp_valid:
- loads: 2 cycles
- SW: 2 cycles
- SB/SH: 3 cycles
- errors: 1 cycle
REQ-025 req_funct3 in {011,110,111}, and stores with funct3 in {100,101}, SHALL always be errors: no RD or WR, resp_error=1, resp_rdata=0.
REQ-026 mem_write_en SHALL be 0 in every state except WR, and an error SHALL never write memory.
REQ-027 req_valid outside IDLE SHALL be ignored, and the core SHALL hold its request until accepted.
REQ-028 mem_address SHALL hold its last value in IDLE and DONE.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) set:
- state IDLE
- req_ready=1
- resp_valid=0
- resp_error=0
- resp_rdata=0
- mem_write_en=0
- mem_address=0
- mem_write_data=0
REQ-030 Reset during RD or WR SHALL abort the access with no memory write issued after reset assertion and no response.

Configuration
REQ-031 Macro MEM_ACCESS_MISALIGN_EN defined: the following SHALL take the error path per REQ-025:
- halfword with addr[0]=1
- word with addr[1:0]!=0
REQ-032 MEM_ACCESS_MISALIGN_EN undefined: misaligned addresses SHALL be force-aligned (H uses addr[1] lane, W ignores addr[1:0]), and resp_error SHALL be 1 only for REQ-025 cases.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- LW: mem word 0x8000_00F0 at 0x10 -> resp_valid at cycle 2, resp_rdata 0x8000_00F0.
- LB/LBU at 0x13, word 0x80xx_xxxx -> rdata 0xFFFF_FF80 / 0x0000_0080.
- SB: wdata 0xAB at 0x21, old word 0x1122_3344 -> single write of 0x1122_AB44 in cycle 2, resp_valid at cycle 3.
- LH at 0x05:
  - macro defined: resp_error=1 at cycle 1, no write.
  - macro undefined: lane [15:0] returned, error=0.
- rst pulsed low during WR of SW -> mem_write_en drops same cycle, no resp_valid, req_ready=1.
- funct3=011 load -> resp_error=1, resp_rdata=0, mem_write_en never asserted.
